xmit: RTL

//  Serial frame transmitter, counterpart of the frame receiver on the same single-wire link.

---
 rtl/frame_pkg.sv | 13 +
 rtl/xmit_if.sv | 22 ++
 rtl/xmit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared framing constants for the single-wire transmitter and receiver
package frame_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;
    localparam int         FRAME_BITS   = 8;
    localparam logic [2:0] LAST_BIT     = 3'(FRAME_BITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

endpackage

// File: rtl/xmit_if.sv
// rtl/xmit_if.sv - parallel writer and serial line signals of the frame transmitter
interface xmit_if;

    logic [7:0] data_in;
    logic       writing;
    logic       data_out;
    logic       full;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output data_in, writing,
        input  data_out, full, busy, done, overrun
    );

    modport slave (
        input  data_in, writing,
        output data_out, full, busy, done, overrun
    );

endinterface

// File: rtl/xmit.sv
// rtl/xmit.sv - serial frame transmitter: one-entry holding register, header + payload shifted MSB first
module xmit
    import frame_pkg::*;
#(
    parameter logic [7:0] HEADER = FRAME_HEADER,
    parameter int         GAP    = 0
) (
    input  logic   clock,
    input  logic   reset,
    xmit_if.slave  port_if
);

    localparam int             GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    shift_q, shift_d;
    logic          full_q, full_d;
    logic          overrun_q, overrun_d;
    logic          data_out_q, data_out_d;
    logic          done_q, done_d;
    logic          load, accept, drop;

    // A frame boundary frees the holding register in the same cycle, so a write there is accepted.
    always_comb begin
        load   = full_q && ((state_q == ST_IDLE) ||
                            (state_q == ST_BODY && cnt_q == LAST_BIT && GAP == 0) ||
                            (state_q == ST_GAP && gcnt_q == GAP_LAST));
        accept = port_if.writing && (!full_q || load);
        drop   = port_if.writing && full_q && !load;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gcnt_d    = gcnt_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        full_d    = full_q;
        overrun_d = overrun_q;

        if (accept) begin
            hold_d    = port_if.data_in;
            overrun_d = 1'b0;
        end else if (drop) begin
            overrun_d = 1'b1;
        end

        if (load)        full_d = accept;
        else if (accept) full_d = 1'b1;

        case (state_q)
            ST_HEAD: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_BODY;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_BODY: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
                    gcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) state_d = ST_IDLE;
                else                    gcnt_d  = gcnt_q + 1'b1;
            end
            default: ;
        endcase

        if (load) begin
            shift_d = hold_q;
            state_d = ST_HEAD;
            cnt_d   = 3'd0;
        end
    end

    // The line is registered, so it is driven from the state being entered.
    always_comb begin
        data_out_d = 1'b0;
        case (state_d)
            ST_HEAD: data_out_d = HEADER[LAST_BIT - cnt_d];
            ST_BODY: data_out_d = shift_d[LAST_BIT - cnt_d];
            default: data_out_d = 1'b0;
        endcase
        done_d = (state_d == ST_BODY) && (cnt_d == LAST_BIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            gcnt_q     <= '0;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
            data_out_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
            full_q     <= full_d;
            overrun_q  <= overrun_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

    assign port_if.data_out = data_out_q;
    assign port_if.full     = full_q;
    assign port_if.busy     = (state_q != ST_IDLE);
    assign port_if.done     = done_q;
    assign port_if.overrun  = overrun_q;

endmodule
